// File: rtl/ram_16x8_prog_pkg.sv
// Shared widths and write-FSM state codes for the 16x8 programmable RAM.
package sap_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [1:0] wr_state_t;

    localparam wr_state_t ST_IDLE    = 2'd0;
    localparam wr_state_t ST_PRESS   = 2'd1;
    localparam wr_state_t ST_WRITE   = 2'd2;
    localparam wr_state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/ram_16x8_prog_if.sv
// Bus-side signal bundle of the programmable RAM; slave is the RAM, master the controller/panel.
interface ram_16x8_prog_if;
    import sap_pkg::*;

    // Handshake: a rising edge with run_prog=1 and Ce=0 is a read request;
    // bus_oe=1 in the following cycle marks bus_out as valid for the bus.
    logic [ADDR_W-1:0] addr;
    logic              run_prog;
    logic              Ce;
    logic [DATA_W-1:0] data_sw;
    logic              wr_btn;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] data_view;
    logic              wr_done;
    logic              busy;
    wr_state_t         wr_state;

    modport master (
        output addr, run_prog, Ce, data_sw, wr_btn,
        input  bus_out, bus_oe, data_view, wr_done, busy, wr_state
    );

    modport slave (
        input  addr, run_prog, Ce, data_sw, wr_btn,
        output bus_out, bus_oe, data_view, wr_done, busy, wr_state
    );

endinterface

// File: rtl/ram_16x8_prog_btn_debounce.sv
// Write push-button conditioning: 2-flop synchronizer, press/release debounce
// and a single-cycle write strobe per accepted press.
module btn_debounce
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      run_prog_i,
    input  logic      btn_i,
    output logic      wr_stb_o,
    output logic      busy_o,
    output wr_state_t state_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign btn_s = sync_q[1];

    // The counter stops at CNT_LAST in both debounce states, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!run_prog_i && btn_s) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_PRESS: begin
                if (run_prog_i || !btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                if (run_prog_i) begin
                    state_d = ST_IDLE;
                end else if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_stb_o = (state_q == ST_WRITE) && !run_prog_i;
    assign busy_o   = (state_q != ST_IDLE);
    assign state_o  = state_q;

endmodule

// File: rtl/ram_16x8_prog.sv
// 16x8 RAM with a registered run-mode bus read port and a debounced
// push-button write path for manual programming from the data switches.
module ram_16x8_prog
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset,
    ram_16x8_prog_if.slave bus
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_stb;
    logic              we;
    logic              busy;
    wr_state_t         wr_state;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0] data_view_q, data_view_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock     (clock),
        .reset     (reset),
        .run_prog_i(bus.run_prog),
        .btn_i     (bus.wr_btn),
        .wr_stb_o  (wr_stb),
        .busy_o    (busy),
        .state_o   (wr_state)
    );

    // Reset overrides a pending strobe; the array itself has no reset so a program survives.
    assign we = wr_stb && !reset;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[bus.addr] <= bus.data_sw;
        end
    end

    // Display forwards the word being written so it shows right after the write cycle.
    always_comb begin
        bus_oe_d    = bus.run_prog && !bus.Ce;
        bus_out_d   = bus_oe_d ? mem_q[bus.addr] : bus_out_q;
        data_view_d = we ? bus.data_sw : mem_q[bus.addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            data_view_q <= '0;
        end else begin
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            data_view_q <= data_view_d;
        end
    end

    assign bus.bus_out   = bus_out_q;
    assign bus.bus_oe    = bus_oe_q;
    assign bus.data_view = data_view_q;
    assign bus.wr_done   = wr_stb;
    assign bus.busy      = busy;
    assign bus.wr_state  = wr_state;

endmodule

// File: tb/tb_ram_16x8_prog.sv
// Self-checking bench for ram_16x8_prog with a 4-cycle debounce; reference is a
// plain memory array plus the rule "a press is accepted after 5 stable high samples".
module tb_ram_16x8_prog;

    logic clock = 1'b0;
    logic reset;

    ram_16x8_prog_if bif ();

    ram_16x8_prog #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model [16];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         hold;
        int         exp_pulses;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds the button for 'hold' cycles, releases it, and counts wr_done pulses.
    task automatic press(input logic [3:0] a, input logic [7:0] d, input int hold, output int pulses);
        logic prev;
        bif.addr    = a;
        bif.data_sw = d;
        bif.wr_btn  = 1'b1;
        pulses      = 0;
        prev        = 1'b0;
        for (int c = 0; c < hold + 14; c++) begin
            if (c == hold) bif.wr_btn = 1'b0;
            step();
            if (prev) check("view_after_write", bif.data_view, d);
            prev = bif.wr_done;
            if (bif.wr_done) pulses++;
        end
        check("busy_idle_after_press", bif.busy, 0);
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp);
        bif.run_prog = 1'b1;
        bif.Ce       = 1'b0;
        bif.addr     = a;
        step();
        check("rd_oe", bif.bus_oe, 1);
        check("rd_data", bif.bus_out, exp);
        bif.Ce = 1'b1;
        step();
        check("rd_oe_drop", bif.bus_oe, 0);
        check("rd_hold", bif.bus_out, exp);
        bif.run_prog = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs();
        check("rst_bus_out", bif.bus_out, 8'h00);
        check("rst_bus_oe", bif.bus_oe, 0);
        check("rst_data_view", bif.data_view, 8'h00);
        check("rst_wr_done", bif.wr_done, 0);
        check("rst_busy", bif.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   p;
        logic found;
        logic [3:0] ra;
        logic [7:0] rd;

        for (int i = 0; i < 16; i++) begin
            tbl[i].addr       = 4'(i);
            tbl[i].data       = 8'(i * 29 + 7);
            tbl[i].hold       = 6 + (i % 5);
            tbl[i].exp_pulses = 1;
        end
        // Debounce boundary: 4 stable samples are too short, 5 are accepted.
        tbl[16] = '{addr: 4'd2, data: 8'h00, hold: 4, exp_pulses: 0};
        tbl[17] = '{addr: 4'd2, data: 8'h5A, hold: 5, exp_pulses: 1};

        bif.addr     = 4'd0;
        bif.run_prog = 1'b0;
        bif.Ce       = 1'b1;
        bif.data_sw  = 8'h00;
        bif.wr_btn   = 1'b0;
        reset        = 1'b1;
        step();
        step();
        check_reset_outputs();
        reset = 1'b0;
        step();

        for (int i = 0; i < 18; i++) begin
            press(tbl[i].addr, tbl[i].data, tbl[i].hold, p);
            check("tbl_pulses", p, tbl[i].exp_pulses);
            if (tbl[i].exp_pulses == 1) model[tbl[i].addr] = tbl[i].data;
            check("tbl_view", bif.data_view, model[tbl[i].addr]);
        end
        for (int i = 0; i < 16; i++) read_chk(4'(i), model[i]);

        // One press held 10 cycles writes exactly once.
        press(4'd3, 8'hA5, 10, p);
        check("s1_pulses", p, 1);
        model[3] = 8'hA5;

        // Short glitches never reach the write.
        bif.addr    = 4'd3;
        bif.data_sw = 8'h11;
        p = 0;
        for (int k = 0; k < 3; k++) begin
            bif.wr_btn = 1'b1;
            for (int c = 0; c < 2; c++) begin
                step();
                if (bif.wr_done) p++;
            end
            bif.wr_btn = 1'b0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (bif.wr_done) p++;
            end
        end
        check("s2_pulses", p, 0);
        check("s2_view", bif.data_view, 8'hA5);

        read_chk(4'd3, 8'hA5);

        // Run mode ignores the write button.
        bif.run_prog = 1'b1;
        press(4'd3, 8'hFF, 20, p);
        check("s4_pulses", p, 0);
        bif.run_prog = 1'b0;
        step();
        read_chk(4'd3, 8'hA5);

        // Program survives reset.
        press(4'd15, 8'h3C, 8, p);
        check("s5_pulses", p, 1);
        model[15] = 8'h3C;
        bif.run_prog = 1'b1;
        bif.Ce       = 1'b0;
        step();
        bif.Ce = 1'b1;
        reset  = 1'b1;
        step();
        check_reset_outputs();
        reset = 1'b0;
        bif.run_prog = 1'b0;
        step();
        read_chk(4'd15, 8'h3C);

        // Mode switch to run during the press aborts it.
        bif.addr    = 4'd7;
        bif.data_sw = 8'h99;
        bif.wr_btn  = 1'b1;
        found = 1'b0;
        p = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (bif.wr_done) p++;
            if (bif.busy) found = 1'b1;
        end
        check("s6_press_seen", found, 1);
        step();
        if (bif.wr_done) p++;
        bif.run_prog = 1'b1;
        step();
        check("s6_busy_drop", bif.busy, 0);
        bif.wr_btn = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bif.wr_done) p++;
        end
        check("s6_pulses", p, 0);
        bif.run_prog = 1'b0;
        step();
        step();
        check("s6_view", bif.data_view, model[7]);

        // Reset during the write cycle wins.
        bif.addr    = 4'd9;
        bif.data_sw = 8'hEE;
        bif.wr_btn  = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            step();
            if (bif.wr_done) found = 1'b1;
        end
        check("s7_write_seen", found, 1);
        reset      = 1'b1;
        bif.wr_btn = 1'b0;
        step();
        check("s7_wr_done", bif.wr_done, 0);
        check("s7_busy", bif.busy, 0);
        reset = 1'b0;
        step();
        step();
        check("s7_view", bif.data_view, model[9]);
        read_chk(4'd9, model[9]);

        // Randomized mix of presses, glitches and reads.
        for (int it = 0; it < 40; it++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: begin
                    press(ra, rd, $urandom_range(5, 12), p);
                    check("rnd_wr_pulses", p, 1);
                    model[ra] = rd;
                    check("rnd_wr_view", bif.data_view, model[ra]);
                end
                1: begin
                    press(ra, rd, $urandom_range(1, 4), p);
                    check("rnd_glitch_pulses", p, 0);
                    check("rnd_glitch_view", bif.data_view, model[ra]);
                end
                default: read_chk(ra, model[ra]);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_16x8_prog.md
RAM_16X8_PROG -- requirements
Module: ram_16x8_prog

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable cycles required on wr_btn for press and for release.
REQ-002 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: addr  input  4  memory address from the address-register block (its Y_ram output).
REQ-005 Port: run_prog  input  1  mode select: 1 = run (execution), 0 = program (manual entry).
REQ-006 Port: Ce  input  1  active-low read enable (bus drive request) from the controller.
REQ-007 Port: data_sw  input  8  manual data switches.
REQ-008 Port: wr_btn  input  1  raw, asynchronous, bouncing write push-button, active-high.
REQ-009 Port: bus_out  output  8  read data toward the shared bus.
REQ-010 Port: bus_oe  output  1  high when bus_out is valid and shall be driven onto the bus.
REQ-011 Port: data_view  output  8  registered contents of mem[addr] for the programming display.
REQ-012 Port: wr_done  output  1  one-cycle pulse on each committed manual write.
REQ-013 Port: busy  output  1  high whenever the write FSM is not in IDLE.

Function
REQ-014 The block SHALL hold 16 words x 8 bits, addressed 0..15; all 4-bit addresses are valid; there is no wrap or out-of-range case.
REQ-015 Run mode: at a rising edge with run_prog=1 and Ce=0, the block SHALL register mem[addr] into bus_out and set bus_oe=1 for the following cycle (1-cycle read latency).
REQ-016 Run mode: at a rising edge with Ce=1, or in program mode, the block SHALL set bus_oe=0 and hold bus_out at its last value.
REQ-017 Run mode: the block SHALL perform no memory writes, whatever the state of wr_btn.
REQ-018 wr_btn SHALL pass through a 2-flop synchronizer before any use; the result is btn_s.
REQ-019 Write FSM states: IDLE, PRESS, WRITE, RELEASE.
REQ-020 IDLE -> PRESS when run_prog=0 and btn_s=1; the counter clears.
REQ-021 PRESS: the counter increments while btn_s=1.
- btn_s=0 -> IDLE.
- Counter reaches DEBOUNCE_CYCLES-1 with btn_s=1 -> WRITE.
REQ-022 WRITE: the FSM SHALL stay exactly one cycle.
- mem[addr] <= data_sw, both sampled on that edge.
- wr_done=1 for that cycle.
- Next state is RELEASE.
REQ-023 RELEASE: the counter increments while btn_s=0 and clears on any btn_s=1.
- Reaching DEBOUNCE_CYCLES-1 -> IDLE.
- Exactly one write per press, however long the button is held.
REQ-024 If run_prog goes to 1 in PRESS or RELEASE, the FSM SHALL return to IDLE on the next edge; if this happens before WRITE, no write occurs.
REQ-025 data_view SHALL update every cycle as mem[addr] registered (1-cycle latency), in both modes.
- A write to the displayed address appears on data_view one cycle after WRITE.
REQ-026 A run-mode read and a program-mode write cannot coincide, because the mode is exclusive.
REQ-027 The debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1) and the counter SHALL never overflow.

Reset
REQ-028 On reset=1 at a rising edge, the following SHALL clear:
- FSM to IDLE and counter to 0.
- Synchronizer flops to 0.
- bus_out=0x00, bus_oe=0, data_view=0x00, wr_done=0, busy=0.
REQ-029 Reset SHALL NOT alter memory contents; a program survives reset.
REQ-030 Reset asserted during WRITE SHALL win; no write is committed on that edge.

Structure
REQ-031 Shared package sap_pkg SHALL hold ADDR_W=4, DATA_W=8 and the write-FSM state enumeration.
REQ-032 One sub-module, btn_debounce, SHALL contain the synchronizer, counter and FSM and emit a single-cycle write strobe; the top level holds the memory array and read registers.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-033 Scenario: program mode, addr=3, data_sw=0xA5, wr_btn high for 10 cycles then low -> exactly one wr_done pulse; data_view=0xA5 one cycle after WRITE.
REQ-034 Scenario: wr_btn glitches high for 2 cycles, 3 times -> no wr_done; mem[3] unchanged.
REQ-035 Scenario: run_prog=1, addr=3, Ce=0 for one cycle -> next cycle bus_oe=1 and bus_out=0xA5; the cycle after, with Ce=1 -> bus_oe=0.
REQ-036 Scenario: run_prog=1, wr_btn held 20 cycles, data_sw=0xFF, addr=3 -> no write; a later read of address 3 returns 0xA5.
REQ-037 Scenario: reset pulsed after programming address 15 with 0x3C -> outputs return to their reset values; a subsequent run read of address 15 returns 0x3C.
REQ-038 Scenario: press begins, then run_prog=1 at press cycle 2 -> busy falls next cycle; no wr_done; memory unchanged.
